// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared binary32 field widths, constants and pipeline payloads
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int FP32_SIGN_W = 1;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_BIAS   = 127;

    localparam logic [31:0] FP32_CANONICAL_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF       = 32'h7F80_0000;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Swap/align stage output: significands carry 3 extra guard/round/sticky bits
    typedef struct packed {
        logic        special;
        logic [31:0] special_val;
        logic        sign;
        logic        zero_sign;
        logic        sub;
        logic [7:0]  exp;
        logic [26:0] sig_l;
        logic [26:0] sig_s;
`ifdef RSD_FP_ADD_FFLAGS_EN
        logic        nv;
`endif
    } align_t;

    typedef struct packed {
        logic        special;
        logic [31:0] special_val;
        logic        sign;
        logic        zero_sign;
        logic [7:0]  exp;
        logic [27:0] sum;
`ifdef RSD_FP_ADD_FFLAGS_EN
        logic        nv;
`endif
    } sum_t;

    typedef struct packed {
        logic [31:0] result;
`ifdef RSD_FP_ADD_FFLAGS_EN
        fflags_t     flags;
`endif
    } out_t;

endpackage
`default_nettype wire

// File: rtl/fp32_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fp32_lzc
// Description : Leading-zero count of a 27-bit significand (27 when all zero)
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_lzc (
    input  logic [26:0] i_vec,
    output logic [4:0]  o_count
);

    // Ascending scan: the highest set bit is the last one to write the count
    always_comb begin
        o_count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_vec[i]) begin
                o_count = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp32_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pipelined_adder
// Description : Pipelined IEEE-754 binary32 adder, round-to-nearest-even.
//               Define RSD_FP_ADD_FFLAGS_EN to add the fflags output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_pipelined_adder
    import fp32_pkg::*;
#(
    parameter int PIPELINE_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    output logic [31:0] result
`ifdef RSD_FP_ADD_FFLAGS_EN
    ,
    output logic [4:0]  fflags
`endif
);

    align_t w_align_d, w_align;
    sum_t   w_sum_d, w_sum;
    out_t   w_out_d, w_out;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_lost;
    logic [31:0] w_big;
    logic [30:0] w_small;
    logic [7:0]  w_big_exp, w_small_exp, w_diff;
    logic [23:0] w_big_man, w_small_man;
    logic [26:0] w_small_ext, w_shifted, w_small_al;

    // ---------------- swap / align ----------------
    always_comb begin
        w_a_nan     = (&lhs[30:23]) & (|lhs[22:0]);
        w_b_nan     = (&rhs[30:23]) & (|rhs[22:0]);
        w_a_inf     = (&lhs[30:23]) & ~(|lhs[22:0]);
        w_b_inf     = (&rhs[30:23]) & ~(|rhs[22:0]);
        w_swap      = (rhs[30:0] > lhs[30:0]);
        w_big       = w_swap ? rhs : lhs;
        w_small     = w_swap ? lhs[30:0] : rhs[30:0];
        w_big_exp   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_small_exp = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_big_man   = {|w_big[30:23], w_big[22:0]};
        w_small_man = {|w_small[30:23], w_small[22:0]};
        w_diff      = w_big_exp - w_small_exp;
        w_small_ext = {w_small_man, 3'b000};
        w_shifted   = w_small_ext >> w_diff[4:0];
        w_lost      = |(w_small_ext & ~(27'h7FF_FFFF << w_diff[4:0]));
        if (w_diff >= 8'd26) begin
            w_small_al = {26'd0, |w_small_man};
        end else begin
            w_small_al = {w_shifted[26:1], w_shifted[0] | w_lost};
        end

        w_align_d           = '0;
        w_align_d.special   = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (lhs[31] ^ rhs[31]))) begin
            w_align_d.special_val = FP32_CANONICAL_NAN;
        end else if (w_a_inf) begin
            w_align_d.special_val = lhs;
        end else begin
            w_align_d.special_val = rhs;
        end
        w_align_d.sign      = w_big[31];
        w_align_d.zero_sign = lhs[31] & rhs[31];
        w_align_d.sub       = lhs[31] ^ rhs[31];
        w_align_d.exp       = w_big_exp;
        w_align_d.sig_l     = {w_big_man, 3'b000};
        w_align_d.sig_s     = w_small_al;
`ifdef RSD_FP_ADD_FFLAGS_EN
        w_align_d.nv        = (w_a_nan & ~lhs[22]) | (w_b_nan & ~rhs[22]) |
                              (w_a_inf & w_b_inf & (lhs[31] ^ rhs[31]));
`endif
    end

    generate
        if (PIPELINE_DEPTH >= 2) begin : g_align_reg
            align_t r_align_q;
            always_ff @(posedge clk) begin
                if (!rst) r_align_q <= '0;
                else      r_align_q <= w_align_d;
            end
            assign w_align = r_align_q;
        end else begin : g_align_comb
            assign w_align = w_align_d;
        end
    endgenerate

    // ---------------- add ----------------
    always_comb begin
        w_sum_d             = '0;
        w_sum_d.special     = w_align.special;
        w_sum_d.special_val = w_align.special_val;
        w_sum_d.sign        = w_align.sign;
        w_sum_d.zero_sign   = w_align.zero_sign;
        w_sum_d.exp         = w_align.exp;
        w_sum_d.sum         = w_align.sub ? ({1'b0, w_align.sig_l} - {1'b0, w_align.sig_s})
                                          : ({1'b0, w_align.sig_l} + {1'b0, w_align.sig_s});
`ifdef RSD_FP_ADD_FFLAGS_EN
        w_sum_d.nv          = w_align.nv;
`endif
    end

    generate
        if (PIPELINE_DEPTH >= 3) begin : g_sum_reg
            sum_t r_sum_q;
            always_ff @(posedge clk) begin
                if (!rst) r_sum_q <= '0;
                else      r_sum_q <= w_sum_d;
            end
            assign w_sum = r_sum_q;
        end else begin : g_sum_comb
            assign w_sum = w_sum_d;
        end
    endgenerate

    // ---------------- normalize / round / pack ----------------
    logic [4:0]  w_lz, w_shamt;
    logic [9:0]  w_exp_ext, w_lim, w_norm_exp, w_fin_exp;
    logic [26:0] w_norm;
    logic [24:0] w_rnd_man;
    logic [23:0] w_fin_man;
    logic        w_rnd_inc, w_ovf, w_zero;

    fp32_lzc u_lzc (
        .i_vec   (w_sum.sum[26:0]),
        .o_count (w_lz)
    );

    always_comb begin
        w_exp_ext = {2'b00, w_sum.exp};
        w_zero    = (w_sum.sum == 28'd0);
        // Left shift never takes the exponent below 1, which yields subnormals
        w_lim     = (w_exp_ext > 10'd1) ? (w_exp_ext - 10'd1) : 10'd0;
        w_shamt   = (w_lim < {5'd0, w_lz}) ? w_lim[4:0] : w_lz;
        if (w_sum.sum[27]) begin
            w_norm     = {w_sum.sum[27:2], |w_sum.sum[1:0]};
            w_norm_exp = w_exp_ext + 10'd1;
        end else begin
            w_norm     = w_sum.sum[26:0] << w_shamt;
            w_norm_exp = w_exp_ext - {5'd0, w_shamt};
        end
        w_rnd_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd_man = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_inc};
        if (w_rnd_man[24]) begin
            w_fin_man = w_rnd_man[24:1];
            w_fin_exp = w_norm_exp + 10'd1;
        end else begin
            w_fin_man = w_rnd_man[23:0];
            w_fin_exp = w_norm_exp;
        end
        w_ovf = (w_fin_exp >= 10'd255);

        w_out_d = '0;
        if (w_sum.special) begin
            w_out_d.result = w_sum.special_val;
        end else if (w_zero) begin
            w_out_d.result = {w_sum.zero_sign, 31'd0};
        end else if (w_ovf) begin
            w_out_d.result = FP32_POS_INF | {w_sum.sign, 31'd0};
        end else begin
            w_out_d.result = {w_sum.sign, (w_fin_man[23] ? w_fin_exp[7:0] : 8'd0),
                              w_fin_man[22:0]};
        end
`ifdef RSD_FP_ADD_FFLAGS_EN
        w_out_d.flags.nv = w_sum.special & w_sum.nv;
        w_out_d.flags.of = ~w_sum.special & ~w_zero & w_ovf;
        w_out_d.flags.nx = ~w_sum.special & ~w_zero & ((|w_norm[2:0]) | w_ovf);
        w_out_d.flags.uf = ~w_sum.special & ~w_zero & ~w_ovf & ~w_fin_man[23] &
                           (|w_norm[2:0]);
`endif
    end

    generate
        if (PIPELINE_DEPTH >= 4) begin : g_tail_reg
            localparam int c_TAIL_LEVELS = PIPELINE_DEPTH - 3;
            out_t r_tail_q [c_TAIL_LEVELS];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < c_TAIL_LEVELS; i++) r_tail_q[i] <= '0;
                end else begin
                    r_tail_q[0] <= w_out_d;
                    for (int i = 1; i < c_TAIL_LEVELS; i++) r_tail_q[i] <= r_tail_q[i-1];
                end
            end
            assign w_out = r_tail_q[c_TAIL_LEVELS-1];
        end else begin : g_tail_comb
            assign w_out = w_out_d;
        end
    endgenerate

    assign result = w_out.result;
`ifdef RSD_FP_ADD_FFLAGS_EN
    assign fflags = w_out.flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp32_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_pipelined_adder
// Description : Scoreboard bench for fp32_pipelined_adder (directed + random)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_pipelined_adder;

    localparam int DEPTH = 3;
    localparam int LAT   = DEPTH - 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        chk;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue = 1'b0;
    logic [31:0] lhs = 32'd0;
    logic [31:0] rhs = 32'd0;
    logic [31:0] result;
`ifdef RSD_FP_ADD_FFLAGS_EN
    logic [4:0]  fflags;
`endif

    exp_t           sb_q[$];
    logic [LAT-1:0] v = '0;
    logic [LAT-1:0] z = '0;
    int             n_vec = 0;
    int             n_err = 0;

    fp32_pipelined_adder #(.PIPELINE_DEPTH(DEPTH)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .lhs    (lhs),
        .rhs    (rhs),
        .result (result)
`ifdef RSD_FP_ADD_FFLAGS_EN
        ,
        .fflags (fflags)
`endif
    );

    always #5 clk = ~clk;

    // Slot tracker: which output cycles carry an issued pair, and which were hit by reset
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            v[i] <= v[i-1];
            z[i] <= z[i-1] | ~rst;
        end
        v[0] <= issue;
        z[0] <= ~rst;
    end

    exp_t        mon_e;
    logic [31:0] mon_r;
    logic [4:0]  mon_f;
    logic        mon_c;
    string       mon_n;

    always @(negedge clk) begin
        if (v[LAT-1]) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: result=%08h with no expected entry", result);
            end else begin
                mon_e = sb_q.pop_front();
                mon_r = z[LAT-1] ? 32'h0 : mon_e.res;
                mon_f = z[LAT-1] ? 5'h0  : mon_e.flg;
                mon_c = z[LAT-1] ? 1'b1  : mon_e.chk;
                mon_n = z[LAT-1] ? {mon_e.name, "/flushed"} : mon_e.name;
                n_vec++;
                if (result !== mon_r) begin
                    n_err++;
                    $display("FAIL %s: result=%08h expected=%08h", mon_n, result, mon_r);
                end
`ifdef RSD_FP_ADD_FFLAGS_EN
                if (mon_c) begin
                    n_vec++;
                    if (fflags !== mon_f) begin
                        n_err++;
                        $display("FAIL %s_flags: fflags=%05b expected=%05b", mon_n, fflags, mon_f);
                    end
                end
`else
                if (mon_c && (mon_f !== mon_e.flg) && !z[LAT-1]) mon_c = 1'b0;
`endif
            end
        end
    end

    task automatic issue_vec(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] er, input logic [4:0] ef,
                             input logic cf, input logic rst_n, input string nm);
        exp_t e;
        @(negedge clk);
        rst   = rst_n;
        lhs   = a;
        rhs   = b;
        issue = 1'b1;
        e.res = er; e.flg = ef; e.chk = cf; e.name = nm;
        sb_q.push_back(e);
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] dexp;
        dexp = 11'(int'(f[30:23]) + 896);
        return $bitstoreal({f[31], dexp, f[22:0], 29'd0});
    endfunction

    // Independent binary64 -> binary32 RNE conversion for the random reference
    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d, m, kept, rem, half;
        int          e, sh, fld;
        logic [31:0] r;
        if (x == 0.0) return 32'h0;
        d    = $realtobits(x);
        e    = int'(d[62:52]) - 1023;
        m    = {11'd0, 1'b1, d[51:0]};
        sh   = (e >= -126) ? 29 : 29 + (-126 - e);
        if (sh > 60) sh = 60;
        kept = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
        if (e >= -126) begin
            if (kept[24]) begin
                kept = kept >> 1;
                e    = e + 1;
            end
            fld = e + 127;
            if (fld >= 255) r = {d[63], 8'hFF, 23'd0};
            else            r = {d[63], fld[7:0], kept[22:0]};
        end else begin
            r = {d[63], (kept[23] ? 8'd1 : 8'd0), kept[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_norm();
        logic [7:0] ex;
        ex = 8'($urandom_range(110, 140));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    localparam logic [4:0] NV = 5'h10, OF = 5'h04, NX = 5'h01;

    initial begin
        logic [31:0] a, b;
        int          budget;

        repeat (3) issue_vec(32'h1234_5678, 32'h3F80_0000, 32'h0, 5'h0, 1'b1, 1'b0, "reset_state");

        issue_vec(32'h3F800000, 32'h3F800000, 32'h40000000, 5'h0,    1'b1, 1'b1, "one_plus_one");
        issue_vec(32'h3F800000, 32'hBF800000, 32'h00000000, 5'h0,    1'b1, 1'b1, "cancel_pos_zero");
        issue_vec(32'h80000000, 32'h80000000, 32'h80000000, 5'h0,    1'b1, 1'b1, "negzero_sum");
        issue_vec(32'h00000000, 32'h80000000, 32'h00000000, 5'h0,    1'b1, 1'b1, "mixed_zero_sum");
        issue_vec(32'h3F800000, 32'h33800000, 32'h3F800000, NX,      1'b1, 1'b1, "tie_even_down");
        issue_vec(32'h3F800001, 32'h33800000, 32'h3F800002, NX,      1'b1, 1'b1, "tie_even_up");
        issue_vec(32'h7F800000, 32'hFF800000, 32'h7FC00000, NV,      1'b1, 1'b1, "inf_minus_inf");
        issue_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, OF | NX, 1'b1, 1'b1, "overflow_pos");
        issue_vec(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, OF | NX, 1'b1, 1'b1, "overflow_neg");
        issue_vec(32'h7F7FFFFF, 32'h73000000, 32'h7F800000, OF | NX, 1'b1, 1'b1, "round_to_overflow");
        issue_vec(32'h00000001, 32'h00000001, 32'h00000002, 5'h0,    1'b1, 1'b1, "subnorm_add");
        issue_vec(32'h007FFFFF, 32'h00000001, 32'h00800000, 5'h0,    1'b1, 1'b1, "subnorm_to_norm");
        issue_vec(32'h00800000, 32'h80000001, 32'h007FFFFF, 5'h0,    1'b1, 1'b1, "norm_to_subnorm");
        issue_vec(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h0,    1'b1, 1'b1, "qnan_in");
        issue_vec(32'h7F800001, 32'h3F800000, 32'h7FC00000, NV,      1'b1, 1'b1, "snan_in");
        issue_vec(32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h0,    1'b1, 1'b1, "neg_inf_plus_fin");
        issue_vec(32'h7F800000, 32'h7F800000, 32'h7F800000, 5'h0,    1'b1, 1'b1, "inf_plus_inf");
        issue_vec(32'h40490FDB, 32'h00000000, 32'h40490FDB, 5'h0,    1'b1, 1'b1, "x_plus_zero");
        issue_vec(32'hC0400000, 32'h80000000, 32'hC0400000, 5'h0,    1'b1, 1'b1, "negx_plus_negzero");
        issue_vec(32'h40400000, 32'hBF800000, 32'h40000000, 5'h0,    1'b1, 1'b1, "three_minus_one");
        issue_vec(32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 5'h0,    1'b1, 1'b1, "renorm_left");
        issue_vec(32'h4B800000, 32'h40000000, 32'h4B800001, 5'h0,    1'b1, 1'b1, "exact_lsb");
        issue_vec(32'h4B800001, 32'h3F800000, 32'h4B800002, NX,      1'b1, 1'b1, "tie_odd_up");
        issue_vec(32'h3F800000, 32'h32000000, 32'h3F800000, NX,      1'b1, 1'b1, "far_align_add");
        issue_vec(32'h3F800000, 32'hB2000000, 32'h3F800000, NX,      1'b1, 1'b1, "far_align_sub");

        for (int i = 0; i < 10; i++) begin
            a = rand_norm();
            b = (i % 3 == 0) ? {~a[31], a[30:23], 23'($urandom)} : rand_norm();
            issue_vec(a, b, r2f(f2r(a) + f2r(b)), 5'h0, 1'b0, 1'b1, "random_pair");
        end

        // Two pairs in flight, then reset: the younger one must be discarded
        issue_vec(32'h40000000, 32'h40000000, 32'h40800000, 5'h0, 1'b1, 1'b1, "pre_reset_a");
        issue_vec(32'h40400000, 32'h40400000, 32'h40C00000, 5'h0, 1'b1, 1'b1, "pre_reset_b");
        issue_vec(32'h3F800000, 32'h3F800000, 32'h0, 5'h0, 1'b1, 1'b0, "in_reset");
        issue_vec(32'h3F800000, 32'h3F800000, 32'h0, 5'h0, 1'b1, 1'b0, "in_reset");
        issue_vec(32'h3FC00000, 32'h3FC00000, 32'h40400000, 5'h0, 1'b1, 1'b1, "post_reset_a");
        issue_vec(32'hC0000000, 32'h3F800000, 32'hBF800000, 5'h0, 1'b1, 1'b1, "post_reset_b");

        @(negedge clk);
        issue = 1'b0;
        rst   = 1'b1;
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d expected results never appeared, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
